// File: rtl/score_pkg.sv
// score_pkg: shared FSM states, BCD constants and saturation limit for the score BCD encoder
package score_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_NINE = 4'h9;
  function automatic int unsigned max_val(input int digits);
    int unsigned m = 1;
    for (int i = 0; i < digits; i++) m = m * 10;
    return m - 1;
  endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble nibble correction, adds 3 to any digit of 5 or more
module bcd_digit_adj
  import score_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  output logic [BCD_W-1:0] q
);
  assign q = d >= BCD_W'(5) ? d + BCD_W'(3) : d;
endmodule

// File: rtl/score_bcd_encoder.sv
// score_bcd_encoder: iterative shift-add-3 binary to BCD converter with valid/ready request side
module score_bcd_encoder
  import score_pkg::*;
#(
  parameter int WIDTH  = 11,
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_score,
  output logic [BCD_W*DIGITS-1:0]   out_bcd,
  output logic                      out_valid,
  output logic                      out_sat
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = BCD_W * DIGITS;
  state_t state, state_nx;
  logic [WIDTH-1:0] bin;
  logic [AW-1:0] acc, adj;
  logic [CW-1:0] cnt;
  logic sat_q;
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (.d(acc[g*BCD_W +: BCD_W]), .q(adj[g*BCD_W +: BCD_W]));
  end
  assign in_ready = state == IDLE;
  always_comb begin
    state_nx = state == IDLE  ? (in_valid ? SHIFT : IDLE) :
               state == SHIFT ? (cnt == CW'(1) ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bin       <= '0;
      acc       <= '0;
      cnt       <= '0;
      sat_q     <= 1'b0;
      out_bcd   <= '0;
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
    end else begin
      state     <= state_nx;
      out_valid <= state == DONE;
      if (state == IDLE && in_valid) begin
        bin   <= in_score;
        acc   <= '0;
        cnt   <= CW'(WIDTH);
        sat_q <= 32'(in_score) > max_val(DIGITS);
      end
      // top-nibble overflow is dropped; saturation replaces such results anyway
      if (state == SHIFT) begin
        {acc, bin} <= {adj[AW-2:0], bin, 1'b0};
        cnt        <= cnt - 1'b1;
      end
      if (state == DONE) begin
        out_bcd <= sat_q ? {DIGITS{BCD_NINE}} : acc;
        out_sat <= sat_q;
      end
    end
  end
endmodule
